// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared types and constants for the RV32I pipeline stall/flush sequencer.
//   pctrl_state_t : stall classification held by the controller
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0)
//   stall_state() : maps the current D-/I-side stall terms to a state
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2,
        BWAIT = 2'd3
    } pctrl_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic pctrl_state_t stall_state(input logic dstall, input logic istall);
        pctrl_state_t s;
        unique case ({dstall, istall})
            2'b10:   s = DWAIT;
            2'b01:   s = IWAIT;
            2'b11:   s = BWAIT;
            default: s = RUN;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
//   One-entry fetch-return buffer. Holds an I-cache response that arrives while
//   the pipeline is frozen for the D-cache.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   capture_i  : store data_i and mark valid (wins over clear/redirect)
//   data_i     : instruction to capture
//   clear_i    : entry consumed by IF/ID
//   redirect_i : entry is wrong-path, discard
//   valid_o    : entry holds an instruction
//   data_o     : buffered instruction
// -----------------------------------------------------------------------------
module fetch_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            capture_i,
    input  logic [XLEN-1:0] data_i,
    input  logic            clear_i,
    input  logic            redirect_i,
    output logic            valid_o,
    output logic [XLEN-1:0] data_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (capture_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clear_i || redirect_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Stall/flush sequencer for the 5-stage RV32I pipeline. Combines load-use,
//   I-/D-cache handshakes and the EX redirect into PC / stage-register enables.
//   Optional performance counters: define PIPE_CTRL_PERF_CNT_EN.
//
//   clk, rst (async, active-low)
//   imem_read/imem_resp/imem_rdata : fetch request and I-cache response
//   dmem_read/dmem_write/dmem_resp : MEM-stage access and D-cache response
//   no_hazard   : 0 = load-use hazard between EX and MEM
//   br_redirect : EX-stage taken branch/jump
//   pc_load, ifid_load, idex_load, exmem_load, memwb_load : register enables
//   ifid_flush, idex_flush, exmem_bubble : NOP injection controls
//   instr_out/instr_valid : instruction presented to IF/ID
//   cnt_dstall/cnt_istall/cnt_loaduse/cnt_flush : saturating counters (macro)
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_read,
    input  logic            imem_resp,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            dmem_read,
    input  logic            dmem_write,
    input  logic            dmem_resp,
    input  logic            no_hazard,
    input  logic            br_redirect,
    output logic            pc_load,
    output logic            ifid_load,
    output logic            idex_load,
    output logic            exmem_load,
    output logic            memwb_load,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_bubble,
    output logic [XLEN-1:0] instr_out,
    output logic            instr_valid
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_dstall,
    output logic [CNT_W-1:0] cnt_istall,
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_flush
`endif
);

    pctrl_state_t    state_q, state_d;
    logic            dstall, istall, freeze;
    logic            ibuf_valid;
    logic [XLEN-1:0] ibuf;

    // A buffered instruction satisfies the fetch, so it masks the I-stall.
    assign dstall = (dmem_read | dmem_write) & ~dmem_resp;
    assign istall = imem_read & ~imem_resp & ~ibuf_valid;
    assign freeze = dstall | istall;

    assign state_d = stall_state(dstall, istall);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by rst so they read 0 during reset without a cycle lag.
    always_comb begin
        pc_load      = 1'b0;
        ifid_load    = 1'b0;
        idex_load    = 1'b0;
        exmem_load   = 1'b0;
        memwb_load   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        if (rst && !freeze) begin
            if (br_redirect) begin
                pc_load    = 1'b1;
                ifid_load  = 1'b1;
                idex_load  = 1'b1;
                exmem_load = 1'b1;
                memwb_load = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (!no_hazard) begin
                exmem_load   = 1'b1;
                memwb_load   = 1'b1;
                exmem_bubble = 1'b1;
            end else begin
                pc_load    = 1'b1;
                ifid_load  = 1'b1;
                idex_load  = 1'b1;
                exmem_load = 1'b1;
                memwb_load = 1'b1;
            end
        end
    end

    fetch_buf #(
        .XLEN(XLEN)
    ) u_fetch_buf (
        .clk_i      (clk),
        .rst_ni     (rst),
        .capture_i  (imem_resp & dstall),
        .data_i     (imem_rdata),
        .clear_i    (ifid_load),
        .redirect_i (ifid_flush),
        .valid_o    (ibuf_valid),
        .data_o     (ibuf)
    );

    assign instr_out   = ibuf_valid ? ibuf : imem_rdata;
    assign instr_valid = rst & (ibuf_valid | imem_resp);

    // A held entry means istall was masked, so no I-wait can have been recorded.
    a_ibuf_no_iwait: assert property (@(posedge clk) disable iff (!rst)
        ibuf_valid |-> (state_q == RUN || state_q == DWAIT));

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_dstall_q, cnt_istall_q, cnt_loaduse_q, cnt_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_dstall_q  <= '0;
            cnt_istall_q  <= '0;
            cnt_loaduse_q <= '0;
            cnt_flush_q   <= '0;
        end else begin
            if (dstall && cnt_dstall_q != '1)
                cnt_dstall_q <= cnt_dstall_q + CNT_W'(1);
            if (istall && !dstall && cnt_istall_q != '1)
                cnt_istall_q <= cnt_istall_q + CNT_W'(1);
            if (exmem_bubble && cnt_loaduse_q != '1)
                cnt_loaduse_q <= cnt_loaduse_q + CNT_W'(1);
            if (ifid_flush && cnt_flush_q != '1)
                cnt_flush_q <= cnt_flush_q + CNT_W'(1);
        end
    end

    assign cnt_dstall  = cnt_dstall_q;
    assign cnt_istall  = cnt_istall_q;
    assign cnt_loaduse = cnt_loaduse_q;
    assign cnt_flush   = cnt_flush_q;
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipeline_ctrl: CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_read, imem_resp;
    logic [31:0] imem_rdata;
    logic        dmem_read, dmem_write, dmem_resp;
    logic        no_hazard, br_redirect;
    logic        pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic        ifid_flush, idex_flush, exmem_bubble;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [4:0]  en;
    logic [2:0]  fl;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .no_hazard(no_hazard), .br_redirect(br_redirect),
        .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
        .exmem_load(exmem_load), .memwb_load(memwb_load),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_bubble(exmem_bubble),
        .instr_out(instr_out), .instr_valid(instr_valid)
    );

    assign en = {pc_load, ifid_load, idex_load, exmem_load, memwb_load};
    assign fl = {ifid_flush, idex_flush, exmem_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0;
        dmem_resp = 0; no_hazard = 1; br_redirect = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); imem_rdata = 32'h0;
        #2 rst = 0; dmem_read = 1; imem_read = 1;
        #1;
        checks++; if (en !== 5'b00000) begin errors++; $display("FAIL reset_en actual=%b required=%b", en, 5'b00000); end
        checks++; if (fl !== 3'b000) begin errors++; $display("FAIL reset_fl actual=%b required=%b", fl, 3'b000); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_ivalid actual=%b required=0", instr_valid); end
        step(); step();
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL reset_state actual=%0d required=%0d", dut.state_q, RUN); end
        checks++; if (en !== 5'b00000) begin errors++; $display("FAIL reset_hold_en actual=%b required=%b", en, 5'b00000); end
        rst = 1; idle();
        #1;
        checks++; if (en !== 5'b11111) begin errors++; $display("FAIL release_en actual=%b required=%b", en, 5'b11111); end
        step();
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL release_state actual=%0d required=%0d", dut.state_q, RUN); end
        checks++; if (en !== 5'b11111) begin errors++; $display("FAIL release_en2 actual=%b required=%b", en, 5'b11111); end
    endtask

    task automatic test_load_use();
        no_hazard = 0; #1;
        checks++; if (en !== 5'b00011) begin errors++; $display("FAIL loaduse_en actual=%b required=%b", en, 5'b00011); end
        checks++; if (fl !== 3'b001) begin errors++; $display("FAIL loaduse_fl actual=%b required=%b", fl, 3'b001); end
        step();
        no_hazard = 1; #1;
        checks++; if (en !== 5'b11111) begin errors++; $display("FAIL loaduse_after_en actual=%b required=%b", en, 5'b11111); end
        checks++; if (fl !== 3'b000) begin errors++; $display("FAIL loaduse_after_fl actual=%b required=%b", fl, 3'b000); end
        step();
    endtask

    task automatic test_dmiss();
        dmem_read = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (en !== 5'b00000) begin errors++; $display("FAIL dmiss_en c%0d actual=%b required=%b", c, en, 5'b00000); end
            step();
            checks++; if (dut.state_q !== DWAIT) begin errors++; $display("FAIL dmiss_state c%0d actual=%0d required=%0d", c, dut.state_q, DWAIT); end
        end
        dmem_resp = 1; #1;
        checks++; if (en !== 5'b11111) begin errors++; $display("FAIL dmiss_resp_en actual=%b required=%b", en, 5'b11111); end
        step();
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL dmiss_resp_state actual=%0d required=%0d", dut.state_q, RUN); end
        idle(); step();
    endtask

    task automatic test_dmiss_ibuf();
        dmem_read = 1; imem_read = 1; #1;
        checks++; if (en !== 5'b00000) begin errors++; $display("FAIL dibuf_c0_en actual=%b required=%b", en, 5'b00000); end
        step();
        checks++; if (dut.state_q !== BWAIT) begin errors++; $display("FAIL dibuf_state_b actual=%0d required=%0d", dut.state_q, BWAIT); end
        imem_resp = 1; imem_rdata = 32'h00A00093; #1;
        checks++; if (instr_out !== 32'h00A00093) begin errors++; $display("FAIL dibuf_c1_iout actual=%h required=%h", instr_out, 32'h00A00093); end
        step();
        imem_resp = 0; imem_rdata = 32'hDEADBEEF; #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL dibuf_held_ivalid actual=%b required=1", instr_valid); end
        checks++; if (instr_out !== 32'h00A00093) begin errors++; $display("FAIL dibuf_held_iout actual=%h required=%h", instr_out, 32'h00A00093); end
        checks++; if (en !== 5'b00000) begin errors++; $display("FAIL dibuf_held_en actual=%b required=%b", en, 5'b00000); end
        checks++; if (dut.state_q !== DWAIT) begin errors++; $display("FAIL dibuf_state_d actual=%0d required=%0d", dut.state_q, DWAIT); end
        step();
        dmem_resp = 1; #1;
        checks++; if (en !== 5'b11111) begin errors++; $display("FAIL dibuf_resp_en actual=%b required=%b", en, 5'b11111); end
        checks++; if (instr_out !== 32'h00A00093) begin errors++; $display("FAIL dibuf_resp_iout actual=%h required=%h", instr_out, 32'h00A00093); end
        step();
        idle(); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL dibuf_cleared actual=%b required=0", instr_valid); end
        checks++; if (instr_out !== 32'hDEADBEEF) begin errors++; $display("FAIL dibuf_cleared_iout actual=%h required=%h", instr_out, 32'hDEADBEEF); end
        step();
    endtask

    task automatic test_loaduse_holds_ibuf();
        dmem_read = 1; imem_read = 1; imem_resp = 1; imem_rdata = 32'h00100113;
        step();
        imem_read = 0; imem_resp = 0; imem_rdata = 32'h0; dmem_resp = 1; no_hazard = 0; #1;
        checks++; if (en !== 5'b00011) begin errors++; $display("FAIL luibuf_en actual=%b required=%b", en, 5'b00011); end
        step();
        idle(); #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL luibuf_kept actual=%b required=1", instr_valid); end
        checks++; if (instr_out !== 32'h00100113) begin errors++; $display("FAIL luibuf_iout actual=%h required=%h", instr_out, 32'h00100113); end
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL luibuf_clear actual=%b required=0", instr_valid); end
    endtask

    task automatic test_redirect_loaduse();
        dmem_read = 1; imem_read = 1; imem_resp = 1; imem_rdata = 32'h00208193;
        step();
        imem_read = 0; imem_resp = 0; imem_rdata = 32'h0;
        dmem_resp = 1; br_redirect = 1; no_hazard = 0; #1;
        checks++; if (en !== 5'b11111) begin errors++; $display("FAIL redir_en actual=%b required=%b", en, 5'b11111); end
        checks++; if (fl !== 3'b110) begin errors++; $display("FAIL redir_fl actual=%b required=%b", fl, 3'b110); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_ibuf_pre actual=%b required=1", instr_valid); end
        step();
        idle(); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_ibuf_clear actual=%b required=0", instr_valid); end
        step();
    endtask

    task automatic test_redirect_istall();
        imem_read = 1; br_redirect = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({en, fl} !== 8'h00) begin errors++; $display("FAIL ristall_frozen c%0d actual=%b required=%b", c, {en, fl}, 8'h00); end
            step();
            checks++; if (dut.state_q !== IWAIT) begin errors++; $display("FAIL ristall_state c%0d actual=%0d required=%0d", c, dut.state_q, IWAIT); end
        end
        imem_resp = 1; imem_rdata = 32'h00000463; #1;
        checks++; if (en !== 5'b11111) begin errors++; $display("FAIL ristall_resp_en actual=%b required=%b", en, 5'b11111); end
        checks++; if (fl !== 3'b110) begin errors++; $display("FAIL ristall_resp_fl actual=%b required=%b", fl, 3'b110); end
        step();
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL ristall_end_state actual=%0d required=%0d", dut.state_q, RUN); end
        idle(); step();
    endtask

    task automatic test_back_to_back();
        dmem_write = 1; dmem_resp = 1; imem_read = 1; imem_resp = 1; imem_rdata = 32'h00312023; #1;
        checks++; if (en !== 5'b11111) begin errors++; $display("FAIL both_resp_en actual=%b required=%b", en, 5'b11111); end
        step();
        idle(); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL both_resp_nobuf actual=%b required=0", instr_valid); end
        no_hazard = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if ({en, fl} !== 8'b00011_001) begin errors++; $display("FAIL b2b_loaduse c%0d actual=%b required=%b", c, {en, fl}, 8'b00011_001); end
            step();
        end
        idle(); step();
    endtask

    task automatic test_reset_mid_stall();
        dmem_read = 1; imem_read = 1; imem_resp = 1; imem_rdata = 32'h00500293;
        step();
        imem_resp = 0; imem_rdata = 32'h0;
        checks++; if (dut.state_q !== DWAIT) begin errors++; $display("FAIL midrst_pre_state actual=%0d required=%0d", dut.state_q, DWAIT); end
        #2 rst = 0; #1;
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL midrst_state actual=%0d required=%0d", dut.state_q, RUN); end
        checks++; if ({en, fl, instr_valid} !== 9'h000) begin errors++; $display("FAIL midrst_outs actual=%b required=%b", {en, fl, instr_valid}, 9'h000); end
        step();
        rst = 1; idle(); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_ibuf_gone actual=%b required=0", instr_valid); end
        checks++; if (en !== 5'b11111) begin errors++; $display("FAIL midrst_release_en actual=%b required=%b", en, 5'b11111); end
        step();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dmiss();
        test_dmiss_ibuf();
        test_loaduse_holds_ibuf();
        test_redirect_loaduse();
        test_redirect_istall();
        test_back_to_back();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Combines the forwarding unit's load-use indication, I-/D-cache handshakes and the EX-stage redirect. Drives PC and pipeline-register load/flush enables.
- Owns a one-entry fetch-return buffer, so an I-cache response that lands while the pipeline is frozen for the D-cache is not lost.

Parameters:
- XLEN, 32, instruction/data width.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- imem_read  in  1  fetch request active this cycle
- imem_resp  in  1  I-cache response valid
- imem_rdata  in  XLEN  I-cache response instruction
- dmem_read  in  1  MEM-stage load request
- dmem_write  in  1  MEM-stage store request
- dmem_resp  in  1  D-cache response valid
- no_hazard  in  1  from forwarding unit; 0 = load-use hazard EX/MEM
- br_redirect  in  1  EX-stage taken branch/jump (PC redirect)
- pc_load  out  1  PC register enable
- ifid_load, idex_load, exmem_load, memwb_load  out  1 each  stage register enables
- ifid_flush, idex_flush  out  1 each  load NOP/invalid control into that register
- exmem_bubble  out  1  load NOP control into EX/MEM (load-use)
- instr_out  out  XLEN  instruction to IF/ID (buffered or imem_rdata)
- instr_valid  out  1  instr_out holds the current fetch result

Behaviour:
- Reset (rst=0, async): state=RUN, ibuf_valid=0, ibuf=0; all load/flush/bubble outputs 0; instr_valid=0.
- State register and ibuf are flops. Every output is a combinational function of state, ibuf_valid/ibuf and current inputs, with no added latency.
- Stall terms:
  - dstall = (dmem_read|dmem_write) & ~dmem_resp.
  - istall = imem_read & ~imem_resp & ~ibuf_valid.
- States, with next-state = f(dstall, istall):
  - RUN: no stall outstanding.
  - DWAIT: dstall only.
  - IWAIT: istall only.
  - BWAIT: both.
- Freeze = dstall|istall. On freeze, all five enables are 0 and flushes/bubble are 0. Highest priority.
- Load-use (no_hazard=0, no freeze):
  - pc_load=ifid_load=idex_load=0.
  - exmem_load=memwb_load=1, exmem_bubble=1.
  - Exactly one bubble per hazard cycle.
- Redirect (br_redirect=1, no freeze):
  - All enables 1; ifid_flush=idex_flush=1.
  - Takes priority over load-use: an instruction under redirect is squashed, so no bubble is inserted.
- Normal (no freeze, no hazard, no redirect): all enables 1, no flush.
- Fetch buffer:
  - Capture: if imem_resp=1 while dstall=1, store imem_rdata in ibuf and set ibuf_valid.
  - instr_out = ibuf_valid ? ibuf : imem_rdata. instr_valid = ibuf_valid | imem_resp.
  - Clear ibuf_valid on the first cycle ifid_load=1 or ifid_flush=1.
  - Redirect clears ibuf_valid: the buffered instruction is wrong-path.
- Simultaneous imem_resp and dmem_resp: pipeline advances; no buffering.
- Reset mid-stall: state returns to RUN immediately; ibuf discarded.

Optional Feature:
- Macro PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs cnt_dstall, cnt_istall, cnt_loaduse, cnt_flush (CNT_W each).
  - Each increments once per cycle its condition drives the outputs; istall counts only when dstall=0.
  - Counters saturate at all-ones; cleared by reset.
- Undefined: those ports and counters do not exist; behaviour otherwise identical.

Decomposition:
- Shared pipeline package:
  - pctrl_state_t enum {RUN, DWAIT, IWAIT, BWAIT}.
  - NOP instruction constant 32'h00000013.
- Sub-module fetch_buf (the 1-entry capture buffer with capture/clear/redirect inputs) is natural.
- Counters stay inline under the macro.

Test Plan:
- Reset with stall inputs active: rst=0 → all enables 0, instr_valid=0. Release rst with no requests → next cycle all enables 1, state RUN.
- Load-use: no_hazard=0 for 1 cycle → pc/ifid/idex_load=0, exmem_bubble=1, memwb_load=1. Following cycle with no_hazard=1 → all enables 1.
- D-miss 4 cycles (dmem_read=1, resp at cycle 4) → enables 0 cycles 0–3, state DWAIT. Cycle 4 all 1, state RUN.
- D-miss with imem_resp in cycle 1 carrying 32'h00A00093 → ibuf_valid=1. On dmem_resp, instr_out=32'h00A00093 with ifid_load=1. Next cycle ibuf_valid=0.
- br_redirect=1 with no_hazard=0 same cycle → all enables 1, ifid_flush=idex_flush=1, exmem_bubble=0. Any valid ibuf is cleared.
- br_redirect=1 during istall → all outputs frozen until imem_resp. Flush asserts in the resp cycle.
